lifo_stack_arbiter: RTL and testbench

Round-robin access controller that shares one 16-bit LIFO stack between NUM_REQ independent requesters. Each requester issues push/pop/peek commands through a valid/ready handshake. The block serialises the commands onto the stack's single-cycle Push/Pop/Peek strobes, pre-checks full/empty to reject illegal operations, and returns a one-hot completion pulse with read data and an error flag. It sits between the client logic and the 8-entry stack in the data-storage subsystem.

---
 rtl/lifo_ctrl_pkg.sv | 26 ++
 rtl/lifo_rr_arbiter.sv | 31 +++
 rtl/lifo_stack_arbiter.sv | 155 +++++++++++++++
 tb/tb_lifo_stack_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_ctrl_pkg.sv
// rtl/lifo_ctrl_pkg.sv - opcodes, FSM states and widths shared by the LIFO stack arbiter
package lifo_ctrl_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam int ERR_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // A command may reach the stack only if the flags say it cannot over/underflow
  function automatic logic cmd_legal(input logic [1:0] op, input logic full, input logic empty);
    case (op)
      OP_PUSH:         cmd_legal = !full;
      OP_POP, OP_PEEK: cmd_legal = !empty;
      default:         cmd_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lifo_rr_arbiter.sv
// rtl/lifo_rr_arbiter.sv - combinational round-robin picker starting after the last grant
module lifo_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    id_o
);

  logic            found;
  logic [ID_W-1:0] cand;

  // Walk the requesters from last_grant+1 around to last_grant; first set bit wins
  always_comb begin
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        id_o          = cand;
      end
    end
  end

endmodule

// File: rtl/lifo_stack_arbiter.sv
// rtl/lifo_stack_arbiter.sv - shares one LIFO stack between NUM_REQ requesters, one command at a time
module lifo_stack_arbiter
  import lifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          Clk_In,
  input  logic                          Reset_N_In,
  input  logic [NUM_REQ-1:0]            Req_Valid_In,
  input  logic [2*NUM_REQ-1:0]          Req_Op_In,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] Req_Data_In,
  output logic [NUM_REQ-1:0]            Req_Ready_Out,
  output logic [NUM_REQ-1:0]            Rsp_Done_Out,
  output logic [DATA_WIDTH-1:0]         Rsp_Data_Out,
  output logic                          Rsp_Err_Out,
  output logic                          Stack_Push_Out,
  output logic                          Stack_Pop_Out,
  output logic                          Stack_Peek_Out,
  output logic [DATA_WIDTH-1:0]         Stack_Data_Out,
  input  logic [DATA_WIDTH-1:0]         Stack_Data_In,
  input  logic                          Stack_Empty_In,
  input  logic                          Stack_Full_In,
  output logic                          Busy_Out,
  output logic [ERR_CNT_WIDTH-1:0]      Err_Count_Out
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_e                   state_q, state_d;
  logic [ID_W-1:0]          last_grant_q, id_q, win_id;
  logic [1:0]               op_q, win_op;
  logic [DATA_WIDTH-1:0]    data_q, win_data;
  logic [NUM_REQ-1:0]       grant;
  logic                     accept, legal;

  logic                     push_q, push_d, pop_q, pop_d, peek_q, peek_d;
  logic [DATA_WIDTH-1:0]    sdata_q, sdata_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0]       done_q, done_d;
  logic                     err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0] errcnt_q, errcnt_d;

  lifo_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i        (Req_Valid_In),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .id_o         (win_id)
  );

  // Select the winner's opcode and push data from the packed request buses
  always_comb begin
    win_op   = OP_PUSH;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_op   = Req_Op_In[2*i +: 2];
        win_data = Req_Data_In[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  assign accept = (state_q == ST_IDLE) && (|grant);
  assign legal  = cmd_legal(win_op, Stack_Full_In, Stack_Empty_In);

  // State register
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Next state: illegal commands skip ISSUE so the stack is never touched
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = legal ? ST_ISSUE : ST_RESP;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Combinational outputs: grant is only offered while idle
  always_comb begin
    Req_Ready_Out = (state_q == ST_IDLE) ? grant : '0;
    Busy_Out      = (state_q != ST_IDLE);
  end

  // Command latch and round-robin pointer, updated on accept
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      op_q         <= OP_PUSH;
      data_q       <= '0;
    end else if (accept) begin
      last_grant_q <= win_id;
      id_q         <= win_id;
      op_q         <= win_op;
      data_q       <= win_data;
    end
  end

  // Next values of strobes, response and error counter
  always_comb begin
    push_d   = accept && legal && (win_op == OP_PUSH);
    pop_d    = accept && legal && (win_op == OP_POP);
    peek_d   = accept && legal && (win_op == OP_PEEK);
    sdata_d  = push_d ? win_data : '0;
    done_d   = '0;
    err_d    = 1'b0;
    rdata_d  = '0;
    errcnt_d = errcnt_q;
    if (accept && !legal) begin
      done_d = grant;
      err_d  = 1'b1;
      if (errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
    end else if (state_q == ST_ISSUE) begin
      done_d[id_q] = 1'b1;
      rdata_d      = (op_q == OP_PUSH) ? '0 : Stack_Data_In;
    end
  end

  // Registered strobes and response; reset drops them at once
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      peek_q   <= 1'b0;
      sdata_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      errcnt_q <= '0;
    end else begin
      push_q   <= push_d;
      pop_q    <= pop_d;
      peek_q   <= peek_d;
      sdata_q  <= sdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign Stack_Push_Out = push_q;
  assign Stack_Pop_Out  = pop_q;
  assign Stack_Peek_Out = peek_q;
  assign Stack_Data_Out = sdata_q;
  assign Rsp_Done_Out   = done_q;
  assign Rsp_Err_Out    = err_q;
  assign Rsp_Data_Out   = rdata_q;
  assign Err_Count_Out  = errcnt_q;

endmodule

// File: tb/tb_lifo_stack_arbiter.sv
// tb/tb_lifo_stack_arbiter.sv - randomized scoreboard bench for lifo_stack_arbiter
module tb_lifo_stack_arbiter;
  localparam int NR    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic              Clk_In = 1'b0;
  logic              Reset_N_In = 1'b0;
  logic [NR-1:0]     Req_Valid_In = '0;
  logic [2*NR-1:0]   Req_Op_In = '0;
  logic [DW*NR-1:0]  Req_Data_In = '0;
  logic [NR-1:0]     Req_Ready_Out, Rsp_Done_Out;
  logic [DW-1:0]     Rsp_Data_Out, Stack_Data_Out;
  logic [DW-1:0]     Stack_Data_In = '0;
  logic              Rsp_Err_Out, Stack_Push_Out, Stack_Pop_Out, Stack_Peek_Out;
  logic              Stack_Empty_In, Stack_Full_In, Busy_Out;
  logic [7:0]        Err_Count_Out;

  always #5 Clk_In = ~Clk_In;

  lifo_stack_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .Clk_In(Clk_In), .Reset_N_In(Reset_N_In),
    .Req_Valid_In(Req_Valid_In), .Req_Op_In(Req_Op_In), .Req_Data_In(Req_Data_In),
    .Req_Ready_Out(Req_Ready_Out), .Rsp_Done_Out(Rsp_Done_Out),
    .Rsp_Data_Out(Rsp_Data_Out), .Rsp_Err_Out(Rsp_Err_Out),
    .Stack_Push_Out(Stack_Push_Out), .Stack_Pop_Out(Stack_Pop_Out), .Stack_Peek_Out(Stack_Peek_Out),
    .Stack_Data_Out(Stack_Data_Out), .Stack_Data_In(Stack_Data_In),
    .Stack_Empty_In(Stack_Empty_In), .Stack_Full_In(Stack_Full_In),
    .Busy_Out(Busy_Out), .Err_Count_Out(Err_Count_Out)
  );

  typedef struct { logic [1:0] op; logic [DW-1:0] data; } cmd_t;
  typedef struct { logic [NR-1:0] done; logic err; logic [DW-1:0] data; int cyc; int ecnt; } rsp_t;
  typedef struct { logic [2:0] strb; logic [DW-1:0] data; int cyc; } stb_t;

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  cmd_t pend [NR][$];
  rsp_t rsp_q [$];
  stb_t stb_q [$];
  logic [NR-1:0] acc_vec = '0;

  logic [DW-1:0] mdl_stk [$];
  int mdl_last = NR - 1;
  int mdl_busy = 0;
  int mdl_err  = 0;

  always @(posedge Clk_In) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bench-side 8-entry stack acting on the falling edge
  logic [DW-1:0] env_mem [DEPTH];
  int env_cnt = 0;
  always @(negedge Clk_In) begin
    if (!Reset_N_In) env_cnt = 0;
    else if (Stack_Push_Out && env_cnt < DEPTH) begin
      env_mem[env_cnt] = Stack_Data_Out;
      env_cnt++;
    end else if (Stack_Pop_Out && env_cnt > 0) begin
      Stack_Data_In = env_mem[env_cnt-1];
      env_cnt--;
    end else if (Stack_Peek_Out && env_cnt > 0) begin
      Stack_Data_In = env_mem[env_cnt-1];
    end
  end
  assign Stack_Empty_In = (env_cnt == 0);
  assign Stack_Full_In  = (env_cnt == DEPTH);

  // Monitor: compares every Done and every strobe against the scoreboard
  always @(negedge Clk_In) begin
    if (!Reset_N_In) begin
      rsp_q.delete();
      stb_q.delete();
    end else begin
      if (Rsp_Done_Out != '0) begin
        if (rsp_q.size() == 0) chk("unexpected_done", Rsp_Done_Out, 0);
        else begin
          rsp_t e;
          e = rsp_q.pop_front();
          chk("rsp_done", Rsp_Done_Out, e.done);
          chk("rsp_err", Rsp_Err_Out, e.err);
          chk("rsp_data", Rsp_Data_Out, e.data);
          chk("rsp_cycle", cyc, e.cyc);
          chk("err_count", Err_Count_Out, e.ecnt);
        end
      end
      if ({Stack_Push_Out, Stack_Pop_Out, Stack_Peek_Out} != 3'b000) begin
        if (stb_q.size() == 0) chk("unexpected_strobe", {Stack_Push_Out, Stack_Pop_Out, Stack_Peek_Out}, 0);
        else begin
          stb_t s;
          s = stb_q.pop_front();
          chk("strobe", {Stack_Push_Out, Stack_Pop_Out, Stack_Peek_Out}, s.strb);
          chk("strobe_data", Stack_Data_Out, s.data);
          chk("strobe_cycle", cyc, s.cyc);
        end
      end else if (Stack_Data_Out != '0) begin
        chk("idle_stack_data", Stack_Data_Out, 0);
      end
    end
  end

  function automatic int pending_total();
    int n = 0;
    for (int i = 0; i < NR; i++) n += pend[i].size();
    return n;
  endfunction

  // One cycle of stimulus plus reference-model prediction of the grant
  task automatic tick(input int pct);
    int w;
    logic [1:0] op;
    logic [DW-1:0] d;
    logic [NR-1:0] exp_rdy;
    rsp_t r;
    stb_t s;
    bit ok;
    @(negedge Clk_In);
    for (int i = 0; i < NR; i++) begin
      if (acc_vec[i]) begin
        Req_Valid_In[i] = 1'b0;
        if (pend[i].size() > 0) void'(pend[i].pop_front());
      end
    end
    acc_vec = '0;
    if (mdl_busy > 0) mdl_busy--;
    for (int i = 0; i < NR; i++) begin
      if (!Req_Valid_In[i] && pend[i].size() > 0 && $urandom_range(0, 99) < pct) begin
        Req_Valid_In[i]          = 1'b1;
        Req_Op_In[2*i +: 2]      = pend[i][0].op;
        Req_Data_In[DW*i +: DW]  = pend[i][0].data;
      end
    end
    #1;
    chk("busy", Busy_Out, mdl_busy != 0);
    w = -1;
    if (mdl_busy == 0) begin
      for (int k = 1; k <= NR; k++) begin
        int j;
        j = (mdl_last + k) % NR;
        if (w < 0 && Req_Valid_In[j]) w = j;
      end
    end
    exp_rdy = (w >= 0) ? NR'(1) << w : '0;
    chk("ready", Req_Ready_Out, exp_rdy);
    acc_vec = Req_Valid_In & Req_Ready_Out;
    if (w >= 0) begin
      op = Req_Op_In[2*w +: 2];
      d  = Req_Data_In[DW*w +: DW];
      ok = (op == 2'b00) ? (mdl_stk.size() < DEPTH) :
           (op == 2'b11) ? 1'b0 : (mdl_stk.size() > 0);
      r.done = exp_rdy;
      r.err  = !ok;
      r.data = '0;
      if (ok) begin
        s.data = '0;
        case (op)
          2'b00: begin s.strb = 3'b100; s.data = d; mdl_stk.push_back(d); end
          2'b01: begin s.strb = 3'b010; r.data = mdl_stk.pop_back(); end
          default: begin s.strb = 3'b001; r.data = mdl_stk[$]; end
        endcase
        s.cyc = cyc + 1;
        stb_q.push_back(s);
        r.cyc = cyc + 2;
        mdl_busy = 3;
      end else begin
        if (mdl_err < 255) mdl_err++;
        r.cyc = cyc + 1;
        mdl_busy = 2;
      end
      r.ecnt = mdl_err;
      rsp_q.push_back(r);
      mdl_last = w;
    end
  endtask

  task automatic drain(input int pct);
    int n = 0;
    while ((pending_total() != 0 || Req_Valid_In != '0 || mdl_busy != 0 || rsp_q.size() != 0) && n < 3000) begin
      tick(pct);
      n++;
    end
    chk("drain_in_time", n < 3000, 1);
  endtask

  task automatic enq(input int r, input logic [1:0] op, input logic [DW-1:0] d);
    cmd_t c;
    c.op = op;
    c.data = d;
    pend[r].push_back(c);
  endtask

  task automatic empty_stack();
    int n;
    n = mdl_stk.size();
    for (int i = 0; i < n; i++) enq(1, 2'b01, '0);
    drain(100);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge Clk_In);
    chk("reset_ready", Req_Ready_Out, 0);
    chk("reset_done", Rsp_Done_Out, 0);
    chk("reset_strobes", {Stack_Push_Out, Stack_Pop_Out, Stack_Peek_Out}, 0);
    chk("reset_busy", Busy_Out, 0);
    chk("reset_errcnt", Err_Count_Out, 0);
    chk("reset_rsp", {Rsp_Err_Out, Rsp_Data_Out, Stack_Data_Out}, 0);
    Reset_N_In = 1'b1;

    enq(0, 2'b00, 16'hA5A5);
    drain(100);
    for (int i = 0; i < NR; i++) enq(i, 2'b00, DW'(i + 1));
    drain(100);
    enq(2, 2'b01, '0);
    drain(100);

    empty_stack();
    enq(0, 2'b01, '0);
    drain(100);

    for (int i = 0; i < 9; i++) enq(i % NR, 2'b00, DW'(16'h0100 + i));
    drain(100);
    enq(0, 2'b10, '0);
    drain(100);
    enq(0, 2'b01, '0);
    drain(100);
    enq(3, 2'b11, 16'hFFFF);
    drain(100);

    for (int i = 0; i < 200; i++) enq($urandom_range(0, NR-1), 2'($urandom_range(0, 3)), DW'($urandom));
    drain(60);

    for (int i = 0; i < 300; i++) enq(i % NR, 2'b11, DW'(i));
    drain(100);
    chk("errcnt_saturated", Err_Count_Out, 8'd255);

    empty_stack();
    enq(0, 2'b00, 16'h5A5A);
    n = 0;
    do begin tick(100); n++; end while (acc_vec == '0 && n < 50);
    chk("issue_reached", n < 50, 1);
    @(posedge Clk_In);
    #1;
    chk("issue_push_strobe", Stack_Push_Out, 1);
    Reset_N_In = 1'b0;
    #1;
    chk("rst_strobes", {Stack_Push_Out, Stack_Pop_Out, Stack_Peek_Out}, 0);
    chk("rst_done", Rsp_Done_Out, 0);
    chk("rst_busy", Busy_Out, 0);
    chk("rst_errcnt", Err_Count_Out, 0);
    Req_Valid_In = '0;
    acc_vec = '0;
    for (int i = 0; i < NR; i++) pend[i].delete();
    mdl_stk.delete();
    mdl_busy = 0;
    mdl_last = NR - 1;
    mdl_err  = 0;
    repeat (2) @(negedge Clk_In);
    Reset_N_In = 1'b1;
    for (int i = 0; i < NR; i++) enq(i, 2'b00, DW'(16'h0A00 + i));
    tick(100);
    chk("first_after_reset", Req_Ready_Out, 4'b0001);
    drain(100);
    chk("stb_queue_empty", stb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
